// File: rtl/uart_pkg.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmit scheduler: data width, default
// timing constants, FSM state encoding and a counter-width helper.
// ---------------------------------------------------------------------------
package uart_pkg;

    localparam int DATA_W         = 8;
    localparam int DEF_TIMEOUT    = 200000;
    localparam int DEF_GAP_CYCLES = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

    // Bits needed for a counter that must hold values 0..max_val.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/rise_detect.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// rise_detect
// Registers one synchronous level input and flags its rising edges.
//
// Ports:
//   clk  in   system clock, rising edge
//   rst  in   asynchronous active-high reset
//   din  in   level input, synchronous to clk
//   rise out  high for one cycle when din goes 0 -> 1
// ---------------------------------------------------------------------------
module rise_detect (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise
);

    logic din_q;
    logic armed;

    // armed stays low for the first edge after reset so a level that was
    // already high through reset release is absorbed into din_q rather than
    // being reported as an edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            din_q <= 1'b0;
            armed <= 1'b0;
        end else begin
            din_q <= din;
            armed <= 1'b1;
        end
    end

    assign rise = armed & din & ~din_q;

endmodule

// File: rtl/uart_tx_scheduler.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// uart_tx_scheduler
// Arbitrates two level-request sources onto one UART transmitter. Each rising
// edge of a request arms a one-deep pending flag; the FSM grants pending
// requesters round-robin, launches a frame, waits for tx_done (bounded by
// TIMEOUT) and then enforces GAP_CYCLES idle cycles before the next frame.
//
// Ports:
//   clk          in   system clock, rising edge
//   rst          in   asynchronous active-high reset
//   req0, req1   in   level requests, synchronous to clk
//   data0, data1 in   byte to send for each requester
//   tx_done      in   one-cycle pulse, UART frame finished
//   tx_start     out  one-cycle pulse launching a frame
//   tx_data      out  byte for the UART, stable for the whole frame
//   ack0, ack1   out  one-cycle pulse, requester's frame completed
//   busy         out  high whenever the FSM is not idle
//   timeout_err  out  sticky, a frame was abandoned on timeout
//
// State | meaning
// ------+--------------------------------------------------------------
// IDLE  | no frame in flight; grants a pending requester if any
// START | tx_start asserted for this single cycle
// WAIT  | waiting for tx_done, bounded by the timeout counter
// GAP   | enforced idle time between frames
// ---------------------------------------------------------------------------
module uart_tx_scheduler
    import uart_pkg::*;
#(
    parameter int TIMEOUT    = DEF_TIMEOUT,
    parameter int GAP_CYCLES = DEF_GAP_CYCLES
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic [DATA_W-1:0] data0,
    input  logic              req1,
    input  logic [DATA_W-1:0] data1,
    input  logic              tx_done,
    output logic              tx_start,
    output logic [DATA_W-1:0] tx_data,
    output logic              ack0,
    output logic              ack1,
    output logic              busy,
    output logic              timeout_err
);

    localparam int CNT_MAX = (TIMEOUT > GAP_CYCLES) ? TIMEOUT : GAP_CYCLES;
    localparam int CNT_W   = cnt_width(CNT_MAX);

    // Down-counter load values: the counter reaches terminal count (0) after
    // exactly TIMEOUT / GAP_CYCLES cycles in the corresponding state.
    localparam logic [CNT_W-1:0] WAIT_LD = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] GAP_LD  = CNT_W'(GAP_CYCLES - 1);

    state_t           state;
    state_t           state_nxt;
    logic             rise0;
    logic             rise1;
    logic             pend0;
    logic             pend1;
    logic             favor1;     // requester 1 wins the next tie
    logic             owner1;     // requester owning the frame in flight
    logic [CNT_W-1:0] cnt;

    logic             grant0;
    logic             grant1;
    logic             cnt_load_wait;
    logic             cnt_load_gap;
    logic             cnt_dec;
    logic             frame_ok;
    logic             frame_abort;

    rise_detect u_rise0 (
        .clk  (clk),
        .rst  (rst),
        .din  (req0),
        .rise (rise0)
    );

    rise_detect u_rise1 (
        .clk  (clk),
        .rst  (rst),
        .din  (req1),
        .rise (rise1)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        grant0        = 1'b0;
        grant1        = 1'b0;
        cnt_load_wait = 1'b0;
        cnt_load_gap  = 1'b0;
        cnt_dec       = 1'b0;
        frame_ok      = 1'b0;
        frame_abort   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (pend0 && (!pend1 || !favor1)) begin
                    grant0    = 1'b1;
                    state_nxt = ST_START;
                end else if (pend1) begin
                    grant1    = 1'b1;
                    state_nxt = ST_START;
                end
            end
            ST_START: begin
                cnt_load_wait = 1'b1;
                state_nxt     = ST_WAIT;
            end
            ST_WAIT: begin
                // A completion on the last allowed cycle still counts as
                // success.
                if (tx_done) begin
                    frame_ok     = 1'b1;
                    cnt_load_gap = 1'b1;
                    state_nxt    = ST_GAP;
                end else if (cnt == '0) begin
                    frame_abort  = 1'b1;
                    cnt_load_gap = 1'b1;
                    state_nxt    = ST_GAP;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ST_GAP: begin
                if (cnt == '0) begin
                    state_nxt = ST_IDLE;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt         <= '0;
            pend0       <= 1'b0;
            pend1       <= 1'b0;
            favor1      <= 1'b0;
            owner1      <= 1'b0;
            tx_data     <= '0;
            ack0        <= 1'b0;
            ack1        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            if (cnt_load_wait) begin
                cnt <= WAIT_LD;
            end else if (cnt_load_gap) begin
                cnt <= GAP_LD;
            end else if (cnt_dec && (cnt != '0)) begin
                cnt <= cnt - 1'b1;
            end

            // An edge while the flag is already set is dropped; the grant
            // cycle itself counts as "already set" for the granted side.
            pend0 <= grant0 ? 1'b0 : (pend0 | rise0);
            pend1 <= grant1 ? 1'b0 : (pend1 | rise1);

            if (grant0 || grant1) begin
                tx_data <= grant0 ? data0 : data1;
                owner1  <= grant1;
                favor1  <= grant0;
            end

            ack0 <= frame_ok & ~owner1;
            ack1 <= frame_ok &  owner1;

            if (frame_abort) begin
                timeout_err <= 1'b1;
            end
        end
    end

    assign tx_start = (state == ST_START);
    assign busy     = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_scheduler.sv
`timescale 1ns/1ps
module tb_uart_tx_scheduler;
    import uart_pkg::*;

    localparam int TIMEOUT = 50;
    localparam int GAP     = 6;

    logic        clk     = 1'b0;
    logic        rst     = 1'b1;
    logic        req0    = 1'b0;
    logic        req1    = 1'b0;
    logic [7:0]  data0   = 8'h00;
    logic [7:0]  data1   = 8'h00;
    logic        tx_done = 1'b0;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        ack0;
    logic        ack1;
    logic        busy;
    logic        timeout_err;

    int passed = 0;
    int failed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    uart_tx_scheduler #(
        .TIMEOUT    (TIMEOUT),
        .GAP_CYCLES (GAP)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req0        (req0),
        .data0       (data0),
        .req1        (req1),
        .data1       (data1),
        .tx_done     (tx_done),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .ack0        (ack0),
        .ack1        (ack1),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_start(input string tag, input int limit);
        int n;
        n = 0;
        while (tx_start !== 1'b1 && n < limit) begin
            tick(1);
            n++;
        end
        check({tag, " tx_start seen"}, {31'd0, tx_start}, 32'd1);
    endtask

    task automatic wait_idle(input string tag, input int limit);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < limit) begin
            tick(1);
            n++;
        end
        check({tag, " back to idle"}, {31'd0, busy}, 32'd0);
    endtask

    // Waits for launch, checks the byte, completes the frame and checks acks.
    task automatic serve(input string tag, input logic [7:0] exp_data,
                         input logic exp_ack0, input logic exp_ack1);
        wait_start(tag, 20);
        check({tag, " tx_data"}, {24'd0, tx_data}, {24'd0, exp_data});
        tick(3);
        tx_done = 1'b1;
        tick(1);
        tx_done = 1'b0;
        check({tag, " ack0"}, {31'd0, ack0}, {31'd0, exp_ack0});
        check({tag, " ack1"}, {31'd0, ack1}, {31'd0, exp_ack1});
        wait_idle(tag, GAP + 5);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(2);
    endtask

    initial begin
        int starts;
        int acks;
        int cd;
        int ack_seen;

        // ---------------- reset values
        tick(2);
        check("rst busy",        {31'd0, busy},        32'd0);
        check("rst tx_start",    {31'd0, tx_start},    32'd0);
        check("rst tx_data",     {24'd0, tx_data},     32'd0);
        check("rst ack0",        {31'd0, ack0},        32'd0);
        check("rst ack1",        {31'd0, ack1},        32'd0);
        check("rst timeout_err", {31'd0, timeout_err}, 32'd0);
        rst = 1'b0;
        tick(2);

        // ---------------- single frame, two-edge latency, gap length
        data0 = 8'h41;
        req0  = 1'b1;
        tick(1);
        check("t1 no start after 1 edge", {31'd0, tx_start}, 32'd0);
        tick(1);
        check("t1 tx_start after 2 edges", {31'd0, tx_start}, 32'd1);
        check("t1 tx_data", {24'd0, tx_data}, 32'h41);
        check("t1 busy", {31'd0, busy}, 32'd1);
        tick(1);
        check("t1 tx_start one pulse", {31'd0, tx_start}, 32'd0);
        tick(9);
        tx_done = 1'b1;
        tick(1);
        tx_done = 1'b0;
        check("t1 ack0", {31'd0, ack0}, 32'd1);
        check("t1 ack1", {31'd0, ack1}, 32'd0);
        tick(1);
        check("t1 ack0 one pulse", {31'd0, ack0}, 32'd0);
        tick(4);
        check("t1 busy during gap end", {31'd0, busy}, 32'd1);
        tick(1);
        check("t1 idle after gap", {31'd0, busy}, 32'd0);
        req0 = 1'b0;
        tick(2);

        // ---------------- simultaneous requests, round-robin alternation
        do_reset();
        data0 = 8'h41;
        data1 = 8'h42;
        req0  = 1'b1;
        req1  = 1'b1;
        serve("t2a", 8'h41, 1'b1, 1'b0);
        serve("t2b", 8'h42, 1'b0, 1'b1);
        req0 = 1'b0;
        req1 = 1'b0;
        tick(2);
        req0 = 1'b1;
        req1 = 1'b1;
        serve("t2c", 8'h41, 1'b1, 1'b0);
        serve("t2d", 8'h42, 1'b0, 1'b1);
        req0 = 1'b0;
        req1 = 1'b0;
        tick(2);

        // ---------------- held request triggers exactly one frame
        data0  = 8'h41;
        req0   = 1'b1;
        starts = 0;
        acks   = 0;
        cd     = 0;
        for (int i = 0; i < 1000; i++) begin
            tx_done = 1'b0;
            if (cd > 0) begin
                cd--;
                if (cd == 0) tx_done = 1'b1;
            end
            tick(1);
            if (tx_start === 1'b1) begin
                starts++;
                cd = 3;
            end
            if (ack0 === 1'b1) acks++;
        end
        tx_done = 1'b0;
        check("t3 frame count", starts, 32'd1);
        check("t3 ack0 count", acks, 32'd1);
        req0 = 1'b0;
        tick(2);

        // ---------------- timeout, then next request still served
        data1 = 8'h55;
        req1  = 1'b1;
        wait_start("t4", 10);
        check("t4 tx_data", {24'd0, tx_data}, 32'h55);
        ack_seen = 0;
        for (int i = 0; i < TIMEOUT + 1; i++) begin
            tick(1);
            if (ack0 === 1'b1 || ack1 === 1'b1) ack_seen++;
            if (i == TIMEOUT - 1)
                check("t4 no err before timeout", {31'd0, timeout_err}, 32'd0);
        end
        check("t4 timeout_err set", {31'd0, timeout_err}, 32'd1);
        check("t4 no ack", ack_seen, 32'd0);
        wait_idle("t4", GAP + 5);
        req1  = 1'b0;
        data0 = 8'h41;
        req0  = 1'b1;
        serve("t4 next", 8'h41, 1'b1, 1'b0);
        check("t4 err sticky", {31'd0, timeout_err}, 32'd1);
        req0 = 1'b0;
        tick(2);

        // ---------------- async reset during WAIT, late tx_done ignored
        data0 = 8'h66;
        req0  = 1'b1;
        wait_start("t5", 10);
        tick(3);
        req0 = 1'b0;
        rst  = 1'b1;
        #1;
        check("t5 busy", {31'd0, busy}, 32'd0);
        check("t5 tx_start", {31'd0, tx_start}, 32'd0);
        check("t5 tx_data", {24'd0, tx_data}, 32'd0);
        check("t5 ack0", {31'd0, ack0}, 32'd0);
        check("t5 timeout_err", {31'd0, timeout_err}, 32'd0);
        tick(1);
        rst = 1'b0;
        tick(2);
        tx_done = 1'b1;
        tick(1);
        tx_done = 1'b0;
        check("t5 late ack0", {31'd0, ack0}, 32'd0);
        check("t5 late ack1", {31'd0, ack1}, 32'd0);
        check("t5 still idle", {31'd0, busy}, 32'd0);

        // ---------------- request held through reset release: no frame
        rst  = 1'b1;
        req0 = 1'b1;
        tick(2);
        rst = 1'b0;
        starts = 0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            if (tx_start === 1'b1 || busy === 1'b1) starts++;
        end
        check("t7 no spurious frame", starts, 32'd0);
        req0 = 1'b0;
        tick(2);

        // ---------------- data0 change during WAIT does not disturb tx_data
        data0 = 8'h77;
        req0  = 1'b1;
        wait_start("t6", 10);
        check("t6 tx_data latched", {24'd0, tx_data}, 32'h77);
        tick(1);
        data0 = 8'h88;
        tick(3);
        check("t6 tx_data held", {24'd0, tx_data}, 32'h77);
        tx_done = 1'b1;
        tick(1);
        tx_done = 1'b0;
        check("t6 ack0", {31'd0, ack0}, 32'd1);
        check("t6 tx_data at end", {24'd0, tx_data}, 32'h77);
        wait_idle("t6", GAP + 5);
        req0 = 1'b0;
        tick(2);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
